dp_ram_bist: RTL

- Initiator-side controller for the 8-bit x 64-entry dual-port RAM. It drives both RAM ports (data/addr/we) and checks the read data (o_a/o_b).
- Runs a March C- style self-test that exercises the write and read paths on both ports, including cross-port visibility.
- Sits beside the RAM, muxed onto its ports by the system during test. It reports pass/fail plus first-failure diagnostics.

---
 rtl/dp_ram_bist_pkg.sv | 37 +++
 rtl/dp_ram_bist_chk.sv | 72 +++++++
 rtl/dp_ram_bist.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/dp_ram_bist_pkg.sv
// Shared types and per-element decode for the dual-port RAM March C- BIST.
package dp_ram_bist_pkg;

  typedef enum logic [2:0] {
    M0, M1, M2, M3, M4, M5, M6
  } elem_e;

  typedef enum logic [1:0] {
    W0, W1, R0, R1
  } op_e;

  localparam int OPS_PER_ADDR = 12;

  function automatic logic elem_port(input elem_e e);
    return e == M5;
  endfunction

  function automatic logic elem_down(input elem_e e);
    return (e == M3) || (e == M4);
  endfunction

  function automatic logic [1:0] elem_ops(input elem_e e);
    return ((e == M0) || (e == M6)) ? 2'd1 : 2'd2;
  endfunction

  function automatic op_e elem_op(input elem_e e, input logic ph);
    op_e op;
    unique case (e)
      M0:         op = W0;
      M1, M3, M5: op = ph ? W1 : R0;
      M2, M4:     op = ph ? W0 : R1;
      default:    op = R1;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/dp_ram_bist_chk.sv
// One-deep read-check pipeline: compares returned data one cycle after
// the read is issued and captures the first failing read.
module dp_ram_bist_chk #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int TAG_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic              ld_port,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_exp,
  input  logic [TAG_W-1:0]  ld_tag,
  input  logic [DATA_W-1:0] rd_a,
  input  logic [DATA_W-1:0] rd_b,
  output logic              mismatch,
  output logic [TAG_W-1:0]  fail_tag,
  output logic              fail_port,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_act
);

  logic              vld;
  logic              port;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] exp;
  logic [TAG_W-1:0]  tag;
  logic [DATA_W-1:0] rd;

  assign rd       = port ? rd_b : rd_a;
  assign mismatch = vld && (rd != exp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld       <= 1'b0;
      port      <= 1'b0;
      addr      <= '0;
      exp       <= '0;
      tag       <= '0;
      fail_tag  <= '0;
      fail_port <= 1'b0;
      fail_addr <= '0;
      fail_exp  <= '0;
      fail_act  <= '0;
    end else begin
      vld <= load;
      if (load) begin
        port <= ld_port;
        addr <= ld_addr;
        exp  <= ld_exp;
        tag  <= ld_tag;
      end
      if (clr) begin
        fail_tag  <= '0;
        fail_port <= 1'b0;
        fail_addr <= '0;
        fail_exp  <= '0;
        fail_act  <= '0;
      end else if (mismatch) begin
        fail_tag  <= tag;
        fail_port <= port;
        fail_addr <= addr;
        fail_exp  <= exp;
        fail_act  <= rd;
      end
    end
  end

endmodule

// File: rtl/dp_ram_bist.sv
// March C- self-test controller driving both ports of a dual-port RAM,
// reporting pass/fail with first-failure diagnostics.
module dp_ram_bist
  import dp_ram_bist_pkg::*;
#(
  parameter int                 DATA_W  = 8,
  parameter int                 ADDR_W  = 6,
  parameter logic [DATA_W-1:0]  PATTERN = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [2:0]        fail_elem,
  output logic              fail_port,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_act,
  output logic [DATA_W-1:0] data_a,
  output logic [ADDR_W-1:0] addr_a,
  output logic              we_a,
  input  logic [DATA_W-1:0] o_a,
  output logic [DATA_W-1:0] data_b,
  output logic [ADDR_W-1:0] addr_b,
  output logic              we_b,
  input  logic [DATA_W-1:0] o_b
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state;
  elem_e             elem;
  logic [ADDR_W-1:0] cnt;
  logic              phase;
  logic              pass_q;

  op_e               op;
  logic              port;
  logic [ADDR_W-1:0] addr;
  logic              run;
  logic              is_wr;
  logic [DATA_W-1:0] pat;
  logic              start_ok;
  logic              last_ph;
  logic              last_addr;
  logic              mismatch;

  assign op        = elem_op(elem, phase);
  assign port      = elem_port(elem);
  assign addr      = elem_down(elem) ? ~cnt : cnt;
  assign run       = state == S_RUN;
  assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE));
  assign last_ph   = {1'b0, phase} == (elem_ops(elem) - 2'd1);
  assign last_addr = &cnt;

  assign busy = (state == S_RUN) || (state == S_DRAIN);
  assign done = state == S_DONE;
  assign pass = pass_q;

  always_comb begin
    is_wr = 1'b0;
    pat   = PATTERN;
    unique case (op)
      W0: is_wr = 1'b1;
      W1: begin
        is_wr = 1'b1;
        pat   = ~PATTERN;
      end
      R0: pat = PATTERN;
      R1: pat = ~PATTERN;
    endcase
  end

  // Only the element's own port is active; the other sits at zero.
  always_comb begin
    data_a = '0;
    addr_a = '0;
    we_a   = 1'b0;
    data_b = '0;
    addr_b = '0;
    we_b   = 1'b0;
    if (run && !port) begin
      we_a   = is_wr;
      addr_a = addr;
      data_a = is_wr ? pat : '0;
    end
    if (run && port) begin
      we_b   = is_wr;
      addr_b = addr;
      data_b = is_wr ? pat : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      elem   <= M0;
      cnt    <= '0;
      phase  <= 1'b0;
      pass_q <= 1'b0;
    end else if (start_ok) begin
      state  <= S_RUN;
      elem   <= M0;
      cnt    <= '0;
      phase  <= 1'b0;
      pass_q <= 1'b0;
    end else if (state == S_RUN) begin
      if (mismatch) begin
        state  <= S_DONE;
        pass_q <= 1'b0;
      end else if (!last_ph) begin
        phase <= 1'b1;
      end else begin
        phase <= 1'b0;
        cnt   <= cnt + ADDR_W'(1);
        if (last_addr) begin
          if (elem == M6) state <= S_DRAIN;
          else elem <= elem_e'(elem + 3'd1);
        end
      end
    end else if (state == S_DRAIN) begin
      state  <= S_DONE;
      pass_q <= !mismatch;
    end
  end

  dp_ram_bist_chk #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .TAG_W  (3)
  ) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (start_ok),
    .load      (run && !is_wr && !mismatch),
    .ld_port   (port),
    .ld_addr   (addr),
    .ld_exp    (pat),
    .ld_tag    (3'(elem)),
    .rd_a      (o_a),
    .rd_b      (o_b),
    .mismatch  (mismatch),
    .fail_tag  (fail_elem),
    .fail_port (fail_port),
    .fail_addr (fail_addr),
    .fail_exp  (fail_exp),
    .fail_act  (fail_act)
  );

endmodule
